// File: rtl/mips_multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Optional performance counters in the top are enabled by MIPS_MCCTRL_PERF_EN.
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_RTYPEEX = 5'd6,
    S_RTYPEWB = 5'd7,
    S_BEQ     = 5'd8,
    S_BNE     = 5'd9,
    S_IEX     = 5'd10,
    S_IWB     = 5'd11,
    S_JUMP    = 5'd12,
    S_JAL     = 5'd13,
    S_JR      = 5'd14,
    S_FAULT   = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10} regdst_t;
  typedef enum logic [1:0] {MR_ALUOUT = 2'b00, MR_DATA = 2'b01, MR_PC = 2'b10} memtoreg_t;
  typedef enum logic [1:0] {SB_B = 2'b00, SB_FOUR = 2'b01, SB_IMM = 2'b10, SB_IMMSH = 2'b11} alusrcb_t;
  typedef enum logic [1:0] {PC_ALURES = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_JR = 2'b11} pcsrc_t;

  // R-type functs that execute through RTYPEEX (jr is dispatched separately)
  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Memory handshake between the controller (master) and the memory (slave).
interface mips_multicycle_controller_if;
  // mem_req is held for the whole access; the access completes on the first
  // cycle mem_ready=1 while mem_req=1. memwrite is qualified by mem_req.
  logic mem_req;
  logic memwrite;
  logic mem_ready;

  modport master (output mem_req, output memwrite, input mem_ready);
  modport slave  (input mem_req, input memwrite, output mem_ready);
endinterface

// File: rtl/mips_multicycle_controller_alu_ctl_dec.sv
// ALU operation decode from controller state, opcode and funct.
module mips_alu_ctl_dec
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  state_t               state,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  logic [2:0] code;

  always_comb begin
    code = ALU_AND;
    case (state)
      S_FETCH, S_DECODE, S_MEMADR: code = ALU_ADD;
      S_BEQ, S_BNE:                code = ALU_SUB;
      S_RTYPEEX: begin
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: code = ALU_AND;
        endcase
      end
      S_IEX: begin
        case (op)
          OP_ADDI: code = ALU_ADD;
          OP_ANDI: code = ALU_AND;
          OP_ORI:  code = ALU_OR;
          OP_SLTI: code = ALU_SLT;
          default: code = ALU_AND;
        endcase
      end
      default: code = ALU_AND;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM with memory handshake, wait timeout and sticky fault.
// Define MIPS_MCCTRL_PERF_EN to add the cyc_cnt / instr_cnt performance counters.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int MAX_WAIT  = 15
`ifdef MIPS_MCCTRL_PERF_EN
  ,
  parameter int CNT_W     = 32
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [5:0]                  op,
  input  logic [5:0]                  funct,
  input  logic                        zero,
  mips_multicycle_controller_if.master mem,
  output logic                        iord,
  output logic                        irwrite,
  output logic                        regwrite,
  output logic [1:0]                  regdst,
  output logic [1:0]                  memtoreg,
  output logic                        alusrca,
  output logic [1:0]                  alusrcb,
  output logic                        immext,
  output logic [1:0]                  pcsrc,
  output logic                        pcen,
  output logic [ALUCTRL_W-1:0]        alucontrol,
  output logic                        fault,
  output logic [4:0]                  state_o
`ifdef MIPS_MCCTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]            cyc_cnt,
  output logic [CNT_W-1:0]            instr_cnt
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t              state;
  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_expired;
  logic                mem_req_d;

  // The MAX_WAIT-th consecutive not-ready cycle traps unless ready arrives on it
  assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem.mem_ready)     state_next = S_DECODE;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE:                          state_next = (funct == FN_JR) ? S_JR : S_RTYPEEX;
          OP_LW, OP_SW:                      state_next = S_MEMADR;
          OP_BEQ:                            state_next = S_BEQ;
          OP_BNE:                            state_next = S_BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IEX;
          OP_J:                              state_next = S_JUMP;
          OP_JAL:                            state_next = S_JAL;
          default:                           state_next = S_FAULT;
        endcase
      end
      S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem.mem_ready)     state_next = S_MEMWB;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_MEMWR: begin
        if (mem.mem_ready)     state_next = S_FETCH;
        else if (wait_expired) state_next = S_FAULT;
      end
      S_RTYPEEX: state_next = funct_valid(funct) ? S_RTYPEWB : S_FAULT;
      S_IEX:     state_next = S_IWB;
      S_MEMWB, S_RTYPEWB, S_IWB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_JR:
                 state_next = S_FETCH;
      S_FAULT:   state_next = S_FAULT;
      default:   state_next = S_FAULT;
    endcase
  end

  always_comb begin
    mem_req_d    = 1'b0;
    mem.memwrite = 1'b0;
    iord         = 1'b0;
    irwrite      = 1'b0;
    regwrite     = 1'b0;
    regdst       = RD_RT;
    memtoreg     = MR_ALUOUT;
    alusrca      = 1'b0;
    alusrcb      = SB_B;
    immext       = 1'b0;
    pcsrc        = PC_ALURES;
    pcen         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_d = 1'b1;
        alusrcb   = SB_FOUR;
        irwrite   = mem.mem_ready;
        pcen      = mem.mem_ready;
      end
      S_DECODE: alusrcb = SB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SB_IMM;
      end
      S_MEMRD: begin
        mem_req_d = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = MR_DATA;
      end
      S_MEMWR: begin
        mem_req_d    = 1'b1;
        mem.memwrite = 1'b1;
        iord         = 1'b1;
      end
      S_RTYPEEX: alusrca = 1'b1;
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = RD_RD;
      end
      S_BEQ, S_BNE: begin
        alusrca = 1'b1;
        pcsrc   = PC_ALUOUT;
        pcen    = (state == S_BEQ) ? zero : ~zero;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = SB_IMM;
        immext  = (op == OP_ANDI) || (op == OP_ORI);
      end
      S_IWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = PC_JUMP;
        pcen  = 1'b1;
      end
      S_JAL: begin
        pcsrc    = PC_JUMP;
        pcen     = 1'b1;
        regwrite = 1'b1;
        regdst   = RD_RA;
        memtoreg = MR_PC;
      end
      S_JR: begin
        pcsrc = PC_JR;
        pcen  = 1'b1;
      end
      default: ;
    endcase
  end

  // A request in flight when reset arrives is withdrawn immediately
  assign mem.mem_req = mem_req_d & ~reset;
  assign fault       = (state == S_FAULT);
  assign state_o     = state;

  mips_alu_ctl_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_ctl_dec (
    .state      (state),
    .op         (op),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
`ifdef MIPS_MCCTRL_PERF_EN
      cyc_cnt   <= '0;
      instr_cnt <= '0;
`endif
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_req_d && !mem.mem_ready && (wait_cnt != WAIT_W'(MAX_WAIT)))
        wait_cnt <= wait_cnt + WAIT_W'(1);
`ifdef MIPS_MCCTRL_PERF_EN
      if (state != S_FAULT)
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      if ((state != S_FETCH) && (state_next == S_FETCH))
        instr_cnt <= instr_cnt + CNT_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed scoreboard bench for mips_multicycle_controller (per-cycle output vectors).
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic [4:0] st;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immext;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alu;
    logic       fault;
  } vec_t;

  localparam int W = $bits(vec_t);

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, irwrite, regwrite, alusrca, immext, pcen, fault;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [4:0] state_o;
`ifdef MIPS_MCCTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  mips_multicycle_controller_if mem ();

  mips_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem        (mem.master),
    .iord       (iord),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .immext     (immext),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .fault      (fault),
    .state_o    (state_o)
`ifdef MIPS_MCCTRL_PERF_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] act_v;

  assign act_v = {state_o, mem.mem_req, mem.memwrite, iord, irwrite, regwrite,
                  regdst, memtoreg, alusrca, alusrcb, immext, pcsrc, pcen,
                  alucontrol, fault};

  // scoreboard monitor: one expected vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] e;
    string        nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (act_v !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act_v, e);
      end
    end
  end

  // expected-vector builders (hand-written encodings)
  function automatic vec_t fetch_e(input logic rdy);
    vec_t v; v = '0;
    v.st = 5'd0; v.mem_req = 1'b1; v.alusrcb = 2'b01; v.alu = 3'b010;
    v.irwrite = rdy; v.pcen = rdy;
    return v;
  endfunction

  function automatic vec_t decode_e();
    vec_t v; v = '0;
    v.st = 5'd1; v.alusrcb = 2'b11; v.alu = 3'b010;
    return v;
  endfunction

  function automatic vec_t rex_e(input logic [2:0] alu);
    vec_t v; v = '0;
    v.st = 5'd6; v.alusrca = 1'b1; v.alu = alu;
    return v;
  endfunction

  function automatic vec_t rwb_e();
    vec_t v; v = '0;
    v.st = 5'd7; v.regwrite = 1'b1; v.regdst = 2'b01;
    return v;
  endfunction

  function automatic vec_t fault_e();
    vec_t v; v = '0;
    v.st = 5'd15; v.fault = 1'b1;
    return v;
  endfunction

  // driver tasks
  task automatic step(input string nm, input vec_t e);
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [2:0] alu);
    op = 6'b000000; funct = fn; mem.mem_ready = 1'b1;
    step("r_fetch", fetch_e(1'b1));
    step("r_decode", decode_e());
    step("r_ex", rex_e(alu));
    step("r_wb", rwb_e());
  endtask

  task automatic branch(input logic [5:0] opc, input logic z, input logic [4:0] st, input logic pc_en);
    vec_t v;
    op = opc; mem.mem_ready = 1'b1; zero = z;
    step("br_fetch", fetch_e(1'b1));
    step("br_decode", decode_e());
    v = '0; v.st = st; v.alusrca = 1'b1; v.alu = 3'b110; v.pcsrc = 2'b01; v.pcen = pc_en;
    step("br_exec", v);
  endtask

  task automatic itype(input logic [5:0] opc, input logic [2:0] alu, input logic zx);
    vec_t v;
    op = opc; mem.mem_ready = 1'b1;
    step("i_fetch", fetch_e(1'b1));
    step("i_decode", decode_e());
    v = '0; v.st = 5'd10; v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alu = alu; v.immext = zx;
    step("i_ex", v);
    v = '0; v.st = 5'd11; v.regwrite = 1'b1;
    step("i_wb", v);
  endtask

  task automatic jtype(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] st,
                       input logic [1:0] pc_sel, input logic link);
    vec_t v;
    op = opc; funct = fn; mem.mem_ready = 1'b1;
    step("j_fetch", fetch_e(1'b1));
    step("j_decode", decode_e());
    v = '0; v.st = st; v.pcsrc = pc_sel; v.pcen = 1'b1;
    if (link) begin v.regwrite = 1'b1; v.regdst = 2'b10; v.memtoreg = 2'b10; end
    step("j_exec", v);
  endtask

  logic [5:0] fn_tab [5];
  logic [2:0] alu_tab[5];

  initial begin
    vec_t v;
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    alu_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem.mem_ready = 1'b0;
    @(posedge clk); #1;
    v = fetch_e(1'b0); v.mem_req = 1'b0;
    step("reset_state", v);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) rtype(fn_tab[i], alu_tab[i]);

    // LW with three not-ready cycles in MEMRD
    op = 6'b100011; mem.mem_ready = 1'b1;
    step("lw_fetch", fetch_e(1'b1));
    step("lw_decode", decode_e());
    v = '0; v.st = 5'd2; v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alu = 3'b010;
    step("lw_memadr", v);
    mem.mem_ready = 1'b0;
    v = '0; v.st = 5'd3; v.mem_req = 1'b1; v.iord = 1'b1;
    for (int i = 0; i < 3; i++) step("lw_memrd_wait", v);
    mem.mem_ready = 1'b1;
    step("lw_memrd_done", v);
    v = '0; v.st = 5'd4; v.regwrite = 1'b1; v.memtoreg = 2'b01;
    step("lw_memwb", v);

    // SW
    op = 6'b101011;
    step("sw_fetch", fetch_e(1'b1));
    step("sw_decode", decode_e());
    v = '0; v.st = 5'd2; v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alu = 3'b010;
    step("sw_memadr", v);
    v = '0; v.st = 5'd5; v.mem_req = 1'b1; v.memwrite = 1'b1; v.iord = 1'b1;
    step("sw_memwr", v);

    branch(6'b000100, 1'b1, 5'd8, 1'b1);
    branch(6'b000100, 1'b0, 5'd8, 1'b0);
    branch(6'b000101, 1'b1, 5'd9, 1'b0);
    branch(6'b000101, 1'b0, 5'd9, 1'b1);

    itype(6'b001101, 3'b001, 1'b1);
    itype(6'b001000, 3'b010, 1'b0);
    itype(6'b001100, 3'b000, 1'b1);
    itype(6'b001010, 3'b111, 1'b0);

    jtype(6'b000010, 6'b000000, 5'd12, 2'b10, 1'b0);
    jtype(6'b000011, 6'b000000, 5'd13, 2'b10, 1'b1);
    jtype(6'b000000, 6'b001000, 5'd14, 2'b11, 1'b0);

    // fourteen wait cycles then ready on the fifteenth still completes
    op = 6'b000010; mem.mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step("fetch_wait14", fetch_e(1'b0));
    mem.mem_ready = 1'b1;
    step("fetch_late_done", fetch_e(1'b1));
    step("late_decode", decode_e());
    v = '0; v.st = 5'd12; v.pcsrc = 2'b10; v.pcen = 1'b1;
    step("late_jump", v);

    // illegal opcode traps and stays trapped
    op = 6'b111111;
    step("ill_fetch", fetch_e(1'b1));
    step("ill_decode", decode_e());
    for (int i = 0; i < 3; i++) step("ill_fault", fault_e());
    do_reset();

    // unknown R-type funct traps after RTYPEEX
    op = 6'b000000; funct = 6'b111111;
    step("badfn_fetch", fetch_e(1'b1));
    step("badfn_decode", decode_e());
    step("badfn_ex", rex_e(3'b000));
    step("badfn_fault", fault_e());
    do_reset();

    // fifteen wait cycles in FETCH times out
    mem.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("fetch_wait15", fetch_e(1'b0));
    step("timeout_fault", fault_e());
    mem.mem_ready = 1'b1;
    step("timeout_sticky", fault_e());
    do_reset();
    step("post_reset_fetch", fetch_e(1'b1));

`ifdef MIPS_MCCTRL_PERF_EN
    do_reset();
    for (int i = 0; i < 4; i++) rtype(6'b100000, 3'b010);
    n_checks++;
    if (instr_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_instr_cnt: got %0d expected 4", instr_cnt);
    end
    n_checks++;
    if (cyc_cnt !== 32'd16) begin
      n_fail++;
      $display("FAIL perf_cyc_cnt: got %0d expected 16", cyc_cnt);
    end
`endif

    // final report
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
